// File: rtl/replica_xchg_ctl.sv
// Per-replica exchange controller for the parallel-tempering salesman array.
// Latches the replica's pairing role at xchg_start, waits for the deciding
// Metropolis result (own result when lower partner, neighbour's result when
// upper partner), then holds the exchange command for max(hold_len,1) cycles.
// Optional accept/try statistics are built only when REPLICA_XCHG_STAT_EN is
// defined; otherwise acc_cnt/try_cnt read 0 and cnt_clr is ignored.
//
// Exchange command encoding (exchange_ex / exchange_mtr):
//   2'd0 NOP | 2'd1 SELF | 2'd2 PREV | 2'd3 FOLW
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no round in progress, command NOP
// WAIT  | role latched, waiting for the deciding valid
// APPLY | command held, hold down-counter running to terminal count 0

module replica_xchg_ctl #(
   parameter int ID          = 0,
   parameter int REPLICA_NUM = 32,
   parameter int HOLD_W      = 4,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              xchg_start,
   input  logic              xchg_phase,
   input  logic              xchg_abort,
   input  logic [HOLD_W-1:0] hold_len,
   input  logic              exchange_shift_d,
   input  logic              test_valid,
   input  logic              test_accept,
   input  logic              prev_valid,
   input  logic              prev_accept,
   output logic              out_valid,
   output logic              out_accept,
   output logic [1:0]        exchange_ex,
   output logic [1:0]        exchange_mtr,
   output logic              busy,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  acc_cnt,
   output logic [CNT_W-1:0]  try_cnt
);

   localparam logic [1:0] XC_NOP  = 2'd0;
   localparam logic [1:0] XC_SELF = 2'd1;
   localparam logic [1:0] XC_PREV = 2'd2;
   localparam logic [1:0] XC_FOLW = 2'd3;

   // (ID-1)%2 has the same parity as (ID+1)%2 whenever ID>0
   localparam logic LOWER_OK  = (ID + 1 < REPLICA_NUM);
   localparam logic UPPER_OK  = (ID > 0);
   localparam logic LOWER_PAR = ((ID % 2) == 1);
   localparam logic UPPER_PAR = (((ID + 1) % 2) == 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} state_t;
   typedef enum logic [1:0] {R_NONE, R_LOWER, R_UPPER} role_t;

   state_t            state;
   role_t             role;
   role_t             role_start;
   logic [1:0]        exchange_l;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_load;
   logic              wait_hit;
   logic              wait_acc;

   // role this replica takes if a round starts now
   always_comb begin
      role_start = R_NONE;
      if (LOWER_OK && (xchg_phase == LOWER_PAR))
         role_start = R_LOWER;
      else if (UPPER_OK && (xchg_phase == UPPER_PAR))
         role_start = R_UPPER;
   end

   assign hold_load = (hold_len == '0) ? '0 : hold_len - HOLD_W'(1);
   assign wait_hit  = (state == S_WAIT) &&
                      (((role == R_LOWER) && test_valid) ||
                       ((role == R_UPPER) && prev_valid));
   assign wait_acc  = (role == R_LOWER) ? test_accept : prev_accept;

   // round sequencing, command register and decision handoff to ID+1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         role       <= R_NONE;
         exchange_l <= XC_NOP;
         hold_cnt   <= '0;
         out_valid  <= 1'b0;
         out_accept <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (xchg_abort) begin
            state      <= S_IDLE;
            exchange_l <= XC_NOP;
            hold_cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  exchange_l <= XC_NOP;
                  if (xchg_start) begin
                     role <= role_start;
                     if (role_start == R_NONE) begin
                        state      <= S_APPLY;
                        exchange_l <= XC_SELF;
                        hold_cnt   <= hold_load;
                     end else begin
                        state <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (wait_hit) begin
                     state    <= S_APPLY;
                     hold_cnt <= hold_load;
                     if (role == R_LOWER) begin
                        exchange_l <= wait_acc ? XC_FOLW : XC_SELF;
                        out_valid  <= 1'b1;
                        out_accept <= test_accept;
                     end else begin
                        exchange_l <= wait_acc ? XC_PREV : XC_SELF;
                     end
                  end
               end
               S_APPLY: begin
                  if (hold_cnt == '0) begin
                     state      <= S_IDLE;
                     exchange_l <= XC_NOP;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
               default: begin
                  state      <= S_IDLE;
                  exchange_l <= XC_NOP;
               end
            endcase
         end
      end
   end

   assign exchange_ex  = exchange_shift_d ? XC_PREV : exchange_l;
   assign exchange_mtr = exchange_l;
   assign busy         = (state != S_IDLE);

`ifdef REPLICA_XCHG_STAT_EN
   logic [CNT_W-1:0] acc_q;
   logic [CNT_W-1:0] try_q;
   logic             rec_hit;

   // an aborted decision is never recorded
   assign rec_hit = wait_hit && !xchg_abort;

   // saturating try/accept statistics, clear wins over increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         try_q <= '0;
      end else if (cnt_clr) begin
         acc_q <= '0;
         try_q <= '0;
      end else if (rec_hit) begin
         if (try_q != '1)
            try_q <= try_q + CNT_W'(1);
         if (wait_acc && (acc_q != '1))
            acc_q <= acc_q + CNT_W'(1);
      end
   end

   assign acc_cnt = acc_q;
   assign try_cnt = try_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign acc_cnt        = '0;
   assign try_cnt        = '0;
`endif

endmodule

// File: doc/replica_xchg_ctl.md
Name: replica_xchg_ctl

Overview:
- Per-replica exchange controller for the parallel-tempering salesman array; one instance per replica position ID.
- Generalised successor of the fixed-pairing exchange decoder: phase-selectable even/odd pairing and a handshaked wait for the Metropolis test result.
- Holds the resulting exchange command for a programmable number of cycles; keeps optional accept/try statistics.
- Drives exchange_ex to the replica data muxes and out_accept/out_valid to the following neighbour.

Parameters:
ID, 0, replica position in the chain (0..REPLICA_NUM-1)
REPLICA_NUM, 32, number of replicas in the chain
HOLD_W, 4, width of the command hold counter
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
xchg_start  in  1  one-cycle pulse: begin one exchange round
xchg_phase  in  1  0: pairs (0,1),(2,3)...; 1: pairs (1,2),(3,4)...
xchg_abort  in  1  force return to IDLE
hold_len  in  HOLD_W  cycles APPLY holds the command (0 treated as 1)
exchange_shift_d  in  1  ordering read/write override: exchange_ex forced to PREV
test_valid  in  1  own Metropolis test result valid
test_accept  in  1  own test result (1 = exchange)
prev_valid  in  1  out_valid of replica ID-1
prev_accept  in  1  out_accept of replica ID-1
out_valid  out  1  own decision valid, to replica ID+1
out_accept  out  1  own decision, to replica ID+1
exchange_ex  out  exchange_command_t  command to data muxes, with shift override
exchange_mtr  out  exchange_command_t  command without override, for monitor
busy  out  1  FSM not in IDLE
cnt_clr  in  1  synchronous clear of statistics
acc_cnt  out  CNT_W  accepted exchanges, saturating
try_cnt  out  CNT_W  attempted exchanges, saturating

Behaviour:
- Role at xchg_start, from xchg_phase and ID:
  - LOWER if (ID%2)==phase and ID+1<REPLICA_NUM.
  - UPPER if ID>0 and ((ID-1)%2)==phase.
  - Otherwise NONE.
  - Role is latched at xchg_start.
- FSM states: IDLE, WAIT, APPLY.
- IDLE:
  - exchange_l=NOP.
  - On xchg_start: role NONE goes to APPLY with exchange_l=SELF; otherwise goes to WAIT.
  - xchg_start in any other state is ignored.
- WAIT, LOWER: waits for test_valid.
  - Cycle after test_valid=1: goes to APPLY with exchange_l=FOLW if test_accept else SELF.
  - Same cycle: out_valid=1 for exactly one cycle, out_accept=test_accept.
- WAIT, UPPER: waits for prev_valid.
  - Cycle after: goes to APPLY with exchange_l=PREV if prev_accept else SELF.
  - test_valid is ignored in this role.
- APPLY:
  - exchange_l is held for max(hold_len,1) cycles, counted by a down-counter loaded on entry.
  - Then goes to IDLE with exchange_l=NOP.
- Latency: APPLY is entered 1 cycle after the qualifying valid, or 1 cycle after xchg_start for NONE.
- Outputs:
  - exchange_ex = PREV when exchange_shift_d=1, else exchange_l. This is combinational.
  - exchange_mtr = exchange_l.
  - busy = (state != IDLE).
- xchg_abort, highest priority in any state: next cycle state=IDLE, exchange_l=NOP, out_valid=0, hold counter cleared. Counters are not updated.
- Simultaneous valid and xchg_abort: abort wins and no decision is recorded.
- out_valid and out_accept are registered. out_accept holds its last value when out_valid=0.
- Reset (async): state=IDLE, exchange_l=NOP, out_valid=0, out_accept=0, role=NONE, hold counter=0, acc_cnt=0, try_cnt=0. Reset mid-round discards the round.
- Counters:
  - try_cnt increments on each entry to APPLY from WAIT.
  - acc_cnt increments when that entry carries an accept.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.
  - Role NONE rounds do not count.

Optional Feature:
- Macro REPLICA_XCHG_STAT_EN.
- Defined: acc_cnt/try_cnt counters and cnt_clr implemented as above.
- Undefined: no counter flops; acc_cnt and try_cnt tied to 0; cnt_clr ignored. All other behaviour is identical.

Test Plan:
- ID=2, N=32, phase=0, hold_len=3: xchg_start, then test_valid=1/test_accept=1 at cycle 4.
  - Cycle 5: out_valid=1, out_accept=1.
  - exchange_mtr=FOLW for cycles 5..7, NOP at cycle 8.
  - try_cnt=1, acc_cnt=1.
- ID=3, phase=0, prev_valid=1 with prev_accept=0: exchange_l=SELF for hold_len cycles, then NOP; try_cnt=1, acc_cnt=0.
- Edge cases at phase=1: ID=0 and ID=31 (N=32) each get SELF 1 cycle after xchg_start, held hold_len cycles, with counters unchanged. Repeat with hold_len=0: SELF for exactly 1 cycle.
- ID=5, phase=1, role LOWER: assert xchg_abort while in WAIT, then test_valid the next cycle.
  - State is IDLE and exchange_l=NOP.
  - No out_valid pulse; counters unchanged.
- exchange_shift_d=1 while in APPLY with FOLW: exchange_ex=PREV, exchange_mtr=FOLW. After deassert, exchange_ex=FOLW.
- CNT_W=2, REPLICA_XCHG_STAT_EN defined: 5 accepted rounds give acc_cnt=3 (saturated). cnt_clr coincident with a 6th accept gives acc_cnt=0. With the macro undefined, both counters read 0 throughout.
